// File: rtl/mult_bank_ctrl.sv
// mult_bank_ctrl: write sequencer steering result beats into the two halves of the multiplier result bank
module mult_bank_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_d1,
    input  logic [DATA_W-1:0] res_d2,
    input  logic [DATA_W-1:0] res_d3,
    input  logic [DATA_W-1:0] res_d4,
    input  logic              flush,
    input  logic              pair_ack,
    output logic              bank_we,
    output logic              bank_wr_mul_pos,
    output logic [DATA_W-1:0] bank_wd1,
    output logic [DATA_W-1:0] bank_wd2,
    output logic [DATA_W-1:0] bank_wd3,
    output logic [DATA_W-1:0] bank_wd4,
    output logic              pair_valid,
    output logic [1:0]        half_full,
    output logic [CNT_W-1:0]  pair_cnt
);
    typedef enum logic [1:0] {EMPTY, HALF, COMMIT, PAIR} state_t;
    state_t                       state_q, state_d;
    logic                         bank_we_q, bank_we_d;
    logic                         pos_q, pos_d;
    logic [3:0][DATA_W-1:0]       wd_q, wd_d;
    logic [1:0]                   half_full_q, half_full_d;
    logic [CNT_W-1:0]             pair_cnt_q, pair_cnt_d;
    logic                         accept;

    // Ready is withheld while in reset so no beat looks accepted on a reset edge
    assign res_ready       = rst_n & ~flush & (state_q == EMPTY || state_q == HALF);
    assign accept          = res_valid & res_ready;
    assign pair_valid      = state_q == PAIR;
    assign bank_we         = bank_we_q;
    assign bank_wr_mul_pos = pos_q;
    assign bank_wd1        = wd_q[0];
    assign bank_wd2        = wd_q[1];
    assign bank_wd3        = wd_q[2];
    assign bank_wd4        = wd_q[3];
    assign half_full       = half_full_q;
    assign pair_cnt        = pair_cnt_q;

    // Next-state: a beat accepted in EMPTY goes to half 0, in HALF to half 1; flush overrides everything
    always_comb begin
        state_d     = state_q;
        bank_we_d   = accept;
        pos_d       = accept ? (state_q == HALF) : pos_q;
        wd_d        = accept ? {res_d4, res_d3, res_d2, res_d1} : wd_q;
        half_full_d = half_full_q;
        pair_cnt_d  = pair_cnt_q;
        if (flush) begin
            state_d     = EMPTY;
            half_full_d = 2'b00;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d     = HALF;
                    half_full_d = 2'b01;
                end
                HALF: if (accept) begin
                    state_d     = COMMIT;
                    half_full_d = 2'b11;
                end
                COMMIT: state_d = PAIR;
                PAIR: if (pair_ack) begin
                    state_d     = EMPTY;
                    half_full_d = 2'b00;
                    pair_cnt_d  = pair_cnt_q + CNT_W'(1);
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            bank_we_q   <= 1'b0;
            pos_q       <= 1'b0;
            wd_q        <= '0;
            half_full_q <= 2'b00;
            pair_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bank_we_q   <= bank_we_d;
            pos_q       <= pos_d;
            wd_q        <= wd_d;
            half_full_q <= half_full_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end
endmodule
